// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle between the register file and its user.
//   rd_addr/rd_data/rd_busy   : NREAD packed read ports (addr, data, scoreboard)
//   wr_en/wr_addr/wr_data     : single write port
//   claim_en/claim_addr       : scoreboard claim (outstanding producer)
//   init_busy                 : high while the post-reset clear sequence runs
// master drives requests (decode/writeback side); slave is the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    claim_en;
  logic [ADDR_W-1:0]       claim_addr;
  logic                    init_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy, init_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy, init_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with a hardware
// clear sequence after reset, optional same-cycle write-to-read bypass and a
// per-register busy scoreboard for RAW hazard detection.
// Ports:
//   clk_i   : clock, all state updates on posedge
//   rst_n_i : asynchronous active-low reset
//   bus     : regfile_mp_if slave (read ports, write port, claim, init_busy)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clearing entry[ptr] each cycle; inputs ignored, outputs 0
// ST_RUN  | normal operation: reads, writes, scoreboard claims
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  // Pointer is one bit wider than the address so the last entry is a
  // distinct terminal count rather than a wrap.
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    ptr_q, ptr_d;
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               wr_ok;
  logic               claim_ok;
  logic [ADDR_W-1:0]  ra [NREAD];
  logic [NREAD-1:0]   hit;

  assign wr_ok    = (state_q == ST_RUN) && bus.wr_en &&
                    !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign claim_ok = (state_q == ST_RUN) && bus.claim_en &&
                    !((ZERO_REG != 0) && (bus.claim_addr == '0));

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    assign ra[g]  = bus.rd_addr[g*ADDR_W +: ADDR_W];
    // Bypass hit: a write this cycle to the address this port is reading.
    assign hit[g] = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == ra[g]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.wr_en) busy_d[bus.wr_addr]    = 1'b0;
        // Applied after the clear: a same-cycle claim means a newer producer.
        if (claim_ok)  busy_d[bus.claim_addr] = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Storage has no reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem_q[ptr_q[ADDR_W-1:0]] <= '0;
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.init_busy = (state_q == ST_INIT);

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NREAD; i++) begin
        if ((ZERO_REG != 0) && (ra[i] == '0)) begin
          bus.rd_data[i*DATA_W +: DATA_W] = '0;
        end else if (hit[i]) begin
          bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
        end else begin
          bus.rd_data[i*DATA_W +: DATA_W] = mem_q[ra[i]];
        end
        bus.rd_busy[i] = busy_q[ra[i]] & ~hit[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Channel 0: defaults (32b, 32 entries, 2 ports, zero reg, bypass)
  // Channel 1: 16b, 8 entries, 4 ports, no zero reg, no bypass
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus_a ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(3), .NREAD(4)) bus_b ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_a));
  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_b));

  int n_vec = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  logic [4:0]  s_ra [2][4];
  logic        s_we [2];
  logic [4:0]  s_wa [2];
  logic [31:0] s_wd [2];
  logic        s_ce [2];
  logic [4:0]  s_ca [2];

  assign bus_a.rd_addr    = {s_ra[0][1], s_ra[0][0]};
  assign bus_a.wr_en      = s_we[0];
  assign bus_a.wr_addr    = s_wa[0];
  assign bus_a.wr_data    = s_wd[0];
  assign bus_a.claim_en   = s_ce[0];
  assign bus_a.claim_addr = s_ca[0];

  assign bus_b.rd_addr    = {s_ra[1][3][2:0], s_ra[1][2][2:0], s_ra[1][1][2:0], s_ra[1][0][2:0]};
  assign bus_b.wr_en      = s_we[1];
  assign bus_b.wr_addr    = s_wa[1][2:0];
  assign bus_b.wr_data    = s_wd[1][15:0];
  assign bus_b.claim_en   = s_ce[1];
  assign bus_b.claim_addr = s_ca[1][2:0];

  // ---- channel configuration ----
  function automatic int depth(int c); return (c == 0) ? 32 : 8; endfunction
  function automatic int nr(int c);    return (c == 0) ? 2 : 4;  endfunction
  function automatic bit zr(int c);    return (c == 0);          endfunction
  function automatic bit bp(int c);    return (c == 0);          endfunction
  function automatic logic [31:0] dmask(int c);
    return (c == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // ---- behavioural model ----
  // m_init counts clear cycles still to go; contents are all zero once it hits 0.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  int          m_init [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_init[c] = depth(c);
        for (int a = 0; a < 32; a++) m_busy[c][a] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_init[c] > 0) begin
          m_init[c]--;
          if (m_init[c] == 0)
            for (int a = 0; a < 32; a++) m_mem[c][a] = 32'h0;
        end else begin
          if (s_we[c] && !(zr(c) && s_wa[c] == 0)) m_mem[c][s_wa[c]] = s_wd[c] & dmask(c);
          if (s_we[c]) m_busy[c][s_wa[c]] = 1'b0;
          if (s_ce[c] && !(zr(c) && s_ca[c] == 0)) m_busy[c][s_ca[c]] = 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_data(int c, int i);
    int a = int'(s_ra[c][i]);
    if (m_init[c] > 0) return 32'h0;
    if (zr(c) && a == 0) return 32'h0;
    if (bp(c) && s_we[c] && int'(s_wa[c]) == a) return s_wd[c] & dmask(c);
    return m_mem[c][a];
  endfunction

  function automatic logic [31:0] exp_busy(int c, int i);
    int a = int'(s_ra[c][i]);
    if (m_init[c] > 0) return 32'h0;
    if (bp(c) && s_we[c] && int'(s_wa[c]) == a) return 32'h0;
    return {31'h0, m_busy[c][a]};
  endfunction

  function automatic logic [31:0] act_data(int c, int i);
    if (c == 0) return bus_a.rd_data[i*32 +: 32];
    return {16'h0, bus_b.rd_data[i*16 +: 16]};
  endfunction

  function automatic logic [31:0] act_busy(int c, int i);
    if (c == 0) return {31'h0, bus_a.rd_busy[i]};
    return {31'h0, bus_b.rd_busy[i]};
  endfunction

  function automatic logic [31:0] act_init(int c);
    return (c == 0) ? {31'h0, bus_a.init_busy} : {31'h0, bus_b.init_busy};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model comparison on every cycle, mid-way between active edges.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("ch%0d init_busy", c), act_init(c), {31'h0, m_init[c] > 0});
        for (int i = 0; i < nr(c); i++) begin
          chk($sformatf("ch%0d rd_data[%0d]", c, i), act_data(c, i), exp_data(c, i));
          chk($sformatf("ch%0d rd_busy[%0d]", c, i), act_busy(c, i), exp_busy(c, i));
        end
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic idle_all();
    for (int c = 0; c < 2; c++) begin
      s_we[c] = 1'b0; s_wa[c] = '0; s_wd[c] = '0;
      s_ce[c] = 1'b0; s_ca[c] = '0;
      for (int i = 0; i < 4; i++) s_ra[c][i] = '0;
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  function automatic logic [4:0] rnd_addr(int c);
    return 5'($urandom_range(0, depth(c) - 1));
  endfunction

  task automatic measure_init(output int len_a, output int len_b);
    bit done_a = 1'b0;
    bit done_b = 1'b0;
    len_a = 0;
    len_b = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) idle_all();
      if (!done_a && !bus_a.init_busy) begin len_a = k; done_a = 1'b1; end
      if (!done_b && !bus_b.init_busy) begin len_b = k; done_b = 1'b1; end
    end
  endtask

  initial begin
    int la, lb;
    idle_all();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset init_busy ch0", act_init(0), 32'h1);
    chk("reset rd_data ch0", act_data(0, 0), 32'h0);
    rst_n = 1'b1;
    // Writes during the clear sequence must be dropped.
    s_we[0] = 1'b1; s_wa[0] = 5'd5; s_wd[0] = 32'hFFFF_FFFF;
    s_we[1] = 1'b1; s_wa[1] = 5'd5; s_wd[1] = 32'hFFFF_FFFF;
    measure_init(la, lb);
    chk("init length ch0", la, 32);
    chk("init length ch1", lb, 8);

    next_cyc();
    s_ra[0][0] = 5'd5; s_ra[0][1] = 5'd31;
    s_ra[1][0] = 5'd5; s_ra[1][1] = 5'd0; s_ra[1][2] = 5'd7; s_ra[1][3] = 5'd3;
    @(negedge clk);
    chk("init wr dropped ch0", act_data(0, 0), 32'h0);
    chk("cleared r31 ch0", act_data(0, 1), 32'h0);
    chk("init wr dropped ch1", act_data(1, 0), 32'h0);

    next_cyc();
    s_we[0] = 1'b1; s_wa[0] = 5'd9; s_wd[0] = 32'hDEAD_BEEF;
    s_ra[0][0] = 5'd9; s_ra[0][1] = 5'd9;
    s_we[1] = 1'b1; s_wa[1] = 5'd3; s_wd[1] = 32'h0000_A5A5;
    s_ra[1][0] = 5'd3; s_ra[1][1] = 5'd3; s_ra[1][2] = 5'd0; s_ra[1][3] = 5'd7;
    @(negedge clk);
    chk("bypass r9 p0", act_data(0, 0), 32'hDEAD_BEEF);
    chk("bypass r9 p1", act_data(0, 1), 32'hDEAD_BEEF);
    chk("no bypass r3", act_data(1, 0), 32'h0);

    next_cyc();
    s_ra[0][0] = 5'd9; s_ra[0][1] = 5'd9;
    s_we[1] = 1'b1; s_wa[1] = 5'd7; s_wd[1] = 32'h0000_0F0F;
    s_ra[1][0] = 5'd3; s_ra[1][1] = 5'd3; s_ra[1][2] = 5'd0; s_ra[1][3] = 5'd7;
    @(negedge clk);
    chk("stored r9 p0", act_data(0, 0), 32'hDEAD_BEEF);
    chk("stored r9 p1", act_data(0, 1), 32'hDEAD_BEEF);
    chk("no bypass r7", act_data(1, 3), 32'h0);

    next_cyc();
    s_ra[1][0] = 5'd3; s_ra[1][1] = 5'd3; s_ra[1][2] = 5'd0; s_ra[1][3] = 5'd7;
    s_we[0] = 1'b1; s_wa[0] = 5'd0; s_wd[0] = 32'h1234_5678;
    s_ra[0][0] = 5'd0; s_ra[0][1] = 5'd0;
    @(negedge clk);
    chk("4port r3 a", act_data(1, 0), 32'h0000_A5A5);
    chk("4port r3 b", act_data(1, 1), 32'h0000_A5A5);
    chk("4port r0", act_data(1, 2), 32'h0);
    chk("4port r7", act_data(1, 3), 32'h0000_0F0F);
    chk("zero reg vs bypass", act_data(0, 0), 32'h0);

    next_cyc();
    s_ra[0][0] = 5'd0; s_ra[0][1] = 5'd0;
    s_we[1] = 1'b1; s_wa[1] = 5'd0; s_wd[1] = 32'h0000_5678;
    @(negedge clk);
    chk("zero reg r0 p0", act_data(0, 0), 32'h0);
    chk("zero reg r0 p1", act_data(0, 1), 32'h0);

    next_cyc();
    s_ce[0] = 1'b1; s_ca[0] = 5'd17; s_ra[0][0] = 5'd17;
    @(negedge clk);
    chk("plain r0 ch1", act_data(1, 0), 32'h0000_5678);
    chk("claim not yet visible", act_busy(0, 0), 32'h0);

    next_cyc();
    s_ra[0][0] = 5'd17;
    @(negedge clk);
    chk("busy r17", act_busy(0, 0), 32'h1);

    next_cyc();
    s_we[0] = 1'b1; s_wa[0] = 5'd17; s_wd[0] = 32'h1; s_ra[0][0] = 5'd17;
    @(negedge clk);
    chk("busy hidden by write", act_busy(0, 0), 32'h0);

    next_cyc();
    s_ra[0][0] = 5'd17;
    @(negedge clk);
    chk("busy cleared r17", act_busy(0, 0), 32'h0);

    next_cyc();
    s_ce[0] = 1'b1; s_ca[0] = 5'd20; s_we[0] = 1'b1; s_wa[0] = 5'd20; s_wd[0] = 32'd7;
    s_ce[1] = 1'b1; s_ca[1] = 5'd2;
    @(negedge clk);

    next_cyc();
    s_ra[0][0] = 5'd20; s_ra[1][0] = 5'd2;
    @(negedge clk);
    chk("claim+write r20 data", act_data(0, 0), 32'd7);
    chk("claim wins r20 busy", act_busy(0, 0), 32'h1);
    chk("busy r2 ch1", act_busy(1, 0), 32'h1);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      next_cyc();
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 4; i++) s_ra[c][i] = rnd_addr(c);
        s_we[c] = 1'($urandom_range(0, 1));
        s_wa[c] = ($urandom_range(0, 3) == 0) ? s_ra[c][0] : rnd_addr(c);
        s_wd[c] = $urandom;
        s_ce[c] = ($urandom_range(0, 2) == 0);
        s_ca[c] = ($urandom_range(0, 3) == 0) ? s_wa[c] : rnd_addr(c);
      end
    end

    // Mid-run reset: set up a busy entry, then abort asynchronously.
    next_cyc();
    s_ce[1] = 1'b1; s_ca[1] = 5'd6;
    next_cyc();
    s_ra[1][0] = 5'd6;
    @(negedge clk);
    chk("busy r6 before reset", act_busy(1, 0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset init_busy ch0", act_init(0), 32'h1);
    chk("async reset init_busy ch1", act_init(1), 32'h1);
    chk("async reset busy ch1", act_busy(1, 0), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    measure_init(la, lb);
    chk("re-init length ch0", la, 32);
    chk("re-init length ch1", lb, 8);
    next_cyc();
    s_ra[1][0] = 5'd6;
    @(negedge clk);
    chk("busy lost after reset", act_busy(1, 0), 32'h0);

    for (int n = 0; n < 100; n++) begin
      next_cyc();
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 4; i++) s_ra[c][i] = rnd_addr(c);
        s_we[c] = 1'($urandom_range(0, 1));
        s_wa[c] = rnd_addr(c);
        s_wd[c] = $urandom;
        s_ce[c] = ($urandom_range(0, 2) == 0);
        s_ca[c] = rnd_addr(c);
      end
    end
    next_cyc();
    @(negedge clk);
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file, the next generation of the datapath register file in the MIPS core. It adds configurable width, depth and read-port count. It also adds a hardware clear sequence after reset, a same-cycle write-to-read bypass, and a per-register busy scoreboard that the pipelined decode stage uses for RAW hazard detection.

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NREAD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, when 1, entry 0 reads as 0, ignores writes and is never busy
- BYPASS, 1, when 1, a write in the current cycle is forwarded to matching read ports combinationally

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NREAD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, combinational from rd_addr; port i is bits [i*DATA_W +: DATA_W]
- rd_busy  out  NREAD  scoreboard busy bit for each read address, combinational
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- claim_en  in  1  marks claim_addr as having an outstanding producer
- claim_addr  in  ADDR_W  register being claimed
- init_busy  out  1  high while the clear sequence runs; the file is unusable while it is high

## Operation
- FSM has two states: INIT and RUN.
- Reset (rst_n low, asynchronous):
  - state becomes INIT, clear pointer becomes 0, all busy bits become 0.
  - init_busy = 1, rd_data = 0, rd_busy = 0.
  - Storage contents are not reset directly.
- INIT:
  - Each cycle writes 0 to entry[ptr], then ptr increments.
  - When ptr = DEPTH-1 is written, the FSM moves to RUN on that same edge.
  - The pointer is ADDR_W+1 bits wide so the terminal count is unambiguous.
  - wr_en and claim_en are ignored (dropped, not queued).
  - rd_data is forced to 0 and rd_busy to 0.
- RUN, write path:
  - When wr_en is high, entry[wr_addr] takes wr_data at posedge.
  - When ZERO_REG=1 and wr_addr=0, the write is discarded.
- RUN, read path:
  - rd_data[i] = entry[rd_addr[i]].
  - When BYPASS=1, wr_en is high and wr_addr = rd_addr[i], rd_data[i] = wr_data instead. This does not apply to address 0 when ZERO_REG=1.
  - When ZERO_REG=1 and rd_addr[i] = 0, rd_data[i] = 0 regardless of bypass.
- Scoreboard:
  - claim_en high sets busy[claim_addr] at posedge.
  - wr_en high clears busy[wr_addr] at posedge.
  - If both target the same address in the same cycle, the claim wins: busy stays 1, because a newer producer is pending.
  - Claims to address 0 are ignored when ZERO_REG=1.
  - rd_busy[i] = busy[rd_addr[i]] AND NOT (BYPASS AND wr_en AND wr_addr = rd_addr[i]). A write in flight therefore hides busy on the same cycle.
- Read ports never conflict. Any number of them may address the same entry.

## Timing
- Clear sequence: init_busy is high for exactly DEPTH cycles after rst_n deasserts (32 cycles at defaults). It falls on the edge that completes the write to entry DEPTH-1.
- Read latency is 0 cycles (combinational).
- Write latency:
  - The value is visible via storage from the cycle after the posedge.
  - With BYPASS=1 it is also visible in the same cycle.
  - With BYPASS=0 it is not visible in the same cycle.
- Busy latency: a claim is visible on rd_busy the cycle after claim_en.
- Reset asserted mid-INIT or mid-RUN aborts immediately and the sequence restarts from ptr 0 after release. Busy bits are lost.
- No clock gating. All outputs are glitch-tolerant combinational paths from registered state and inputs.

## Test plan
- Reset release, defaults -> init_busy stays high 32 cycles then 0. Reading every address afterwards returns 0. A wr_en pulse to address 5 during INIT leaves entry 5 at 0.
- Write 0xDEADBEEF to r9, read r9 on both ports next cycle -> both rd_data equal 0xDEADBEEF. With BYPASS=1, the same-cycle read also returns 0xDEADBEEF. With BYPASS=0, the same-cycle read returns the old value 0.
- Write 0x12345678 to r0 with ZERO_REG=1 -> r0 reads 0 on all ports. With ZERO_REG=0 -> r0 reads 0x12345678.
- Claim r17, then read r17 -> rd_busy=1. Writing r17 in a later cycle gives rd_busy=0 in that cycle (bypass) and rd_busy=0 after it.
- Same-cycle claim_en and wr_en on r20 with data 7 -> entry reads 7 and busy remains 1 the next cycle.
- NREAD=4, DATA_W=16, ADDR_W=3 -> INIT lasts 8 cycles. Four simultaneous reads of r3, r3, r0, r7 after writes of 0xA5A5 to r3 and 0x0F0F to r7 return 0xA5A5, 0xA5A5, 0, 0x0F0F. Asserting rst_n low mid-run makes init_busy high immediately and clears all busy bits.
